mode_switcher: RTL and testbench

- Parametrised top-level mode arbiter for the piano; successor to the fixed 3-mode speaker mux.
- Debounces the mode selector and maps out-of-range codes to a default mode.
- Enables exactly one mode engine at a time and inserts a timed mute gap on every switch, so the speaker never glitches between engines.
- Sits between the mode engines (free play, auto play, learning, …) and the board speaker/LED pins.

---
 rtl/mode_switcher_if.sv | 26 ++
 rtl/mode_switcher.sv | 171 +++++++++++++++++
 tb/tb_mode_switcher.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mode_switcher_if.sv
// rtl/mode_switcher_if.sv - engine/speaker side signal bundle for mode_switcher
interface mode_switcher_if #(
    parameter int N_MODES = 4,
    parameter int SEL_W   = 3,
    parameter int NOTE_W  = 4
);
    logic [SEL_W-1:0]          mode_select;
    logic [N_MODES-1:0]        spk_in;
    logic [N_MODES*NOTE_W-1:0] note_in;
    logic                      speaker;
    logic [NOTE_W-1:0]         note_out;
    logic [SEL_W-1:0]          active_mode;
    logic [N_MODES-1:0]        mode_en;
    logic                      switching;
    logic                      loud;

    modport master (
        output mode_select, spk_in, note_in,
        input  speaker, note_out, active_mode, mode_en, switching, loud
    );

    modport slave (
        input  mode_select, spk_in, note_in,
        output speaker, note_out, active_mode, mode_en, switching, loud
    );
endinterface

// File: rtl/mode_switcher.sv
// rtl/mode_switcher.sv - debounced mode arbiter with timed mute gap; MODE_SWITCH_CHIME_EN adds a switch chime
module mode_switcher #(
    parameter int N_MODES       = 4,
    parameter int SEL_W         = 3,
    parameter int NOTE_W        = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int MUTE_CYCLES   = 8,
    parameter int DEFAULT_MODE  = 0
`ifdef MODE_SWITCH_CHIME_EN
    ,
    parameter int CHIME_DIV     = 2
`endif
) (
    input logic            clk,
    input logic            reset,
    mode_switcher_if.slave bus
);
    localparam int CNT_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int MUTE_W = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
    localparam logic [SEL_W:0]       N_MODES_EXT = (SEL_W+1)'(N_MODES);
    localparam logic [SEL_W-1:0]     DEF_SEL     = SEL_W'(DEFAULT_MODE);
    localparam logic [CNT_W-1:0]     CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [MUTE_W-1:0]    MUTE_LAST   = MUTE_W'(MUTE_CYCLES - 1);
    localparam logic [N_MODES-1:0]   DEFAULT_OH  = N_MODES'(1) << DEFAULT_MODE;
`ifdef MODE_SWITCH_CHIME_EN
    localparam int CHIME_W = (CHIME_DIV > 1) ? $clog2(CHIME_DIV) : 1;
    localparam logic [CHIME_W-1:0]   CHIME_LAST  = CHIME_W'(CHIME_DIV - 1);
`endif

    typedef enum logic {ST_ACTIVE, ST_MUTE} state_t;

    state_t              state;
    logic [SEL_W-1:0]    candidate;
    logic [CNT_W-1:0]    stable_cnt;
    logic [SEL_W-1:0]    target;
    logic [SEL_W-1:0]    active_q;
    logic [MUTE_W-1:0]   mute_cnt;
    logic [N_MODES-1:0]  mode_en_q;
    logic                speaker_q;
    logic [NOTE_W-1:0]   note_q;
    logic                switching_q;
    logic                loud_q;
`ifdef MODE_SWITCH_CHIME_EN
    logic [CHIME_W-1:0]  chime_cnt;
`endif

    logic [SEL_W-1:0]    mapped_sel;
    logic [SEL_W-1:0]    target_ref;
    logic                stable;
    logic                req;
    logic                sel_spk;
    logic [NOTE_W-1:0]   sel_note;
    logic [N_MODES-1:0]  target_oh;

    // During a gap a request is judged against the pending target, so a re-request restarts the gap
    always_comb begin
        mapped_sel = ({1'b0, candidate} < N_MODES_EXT) ? candidate : DEF_SEL;
        target_ref = (state == ST_MUTE) ? target : active_q;
        stable     = (stable_cnt == CNT_LAST);
        req        = stable && (mapped_sel != target_ref);
    end

    // Constant-index compares keep slice arithmetic exact for any N_MODES up to 2^SEL_W
    always_comb begin
        sel_spk   = 1'b0;
        sel_note  = '0;
        target_oh = '0;
        for (int i = 0; i < N_MODES; i++) begin
            if (active_q == SEL_W'(i)) begin
                sel_spk  = bus.spk_in[i];
                sel_note = bus.note_in[i*NOTE_W +: NOTE_W];
            end
            if (target == SEL_W'(i)) begin
                target_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            candidate  <= DEF_SEL;
            stable_cnt <= '0;
        end else if (bus.mode_select != candidate) begin
            candidate  <= bus.mode_select;
            stable_cnt <= '0;
        end else if (stable_cnt != CNT_LAST) begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_ACTIVE;
            target      <= DEF_SEL;
            active_q    <= DEF_SEL;
            mute_cnt    <= '0;
            mode_en_q   <= DEFAULT_OH;
            speaker_q   <= 1'b0;
            note_q      <= '0;
            switching_q <= 1'b0;
            loud_q      <= 1'b1;
`ifdef MODE_SWITCH_CHIME_EN
            chime_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (req) begin
                        state       <= ST_MUTE;
                        target      <= mapped_sel;
                        mute_cnt    <= '0;
                        mode_en_q   <= '0;
                        note_q      <= '0;
                        switching_q <= 1'b1;
`ifdef MODE_SWITCH_CHIME_EN
                        speaker_q   <= 1'b1;
                        loud_q      <= 1'b1;
                        chime_cnt   <= '0;
`else
                        speaker_q   <= 1'b0;
                        loud_q      <= 1'b0;
`endif
                    end else begin
                        speaker_q <= sel_spk;
                        note_q    <= sel_note;
                    end
                end
                ST_MUTE: begin
                    note_q <= '0;
                    if (req) begin
                        target   <= mapped_sel;
                        mute_cnt <= '0;
`ifdef MODE_SWITCH_CHIME_EN
                        speaker_q <= 1'b1;
                        chime_cnt <= '0;
`else
                        speaker_q <= 1'b0;
`endif
                    end else if (mute_cnt == MUTE_LAST) begin
                        state       <= ST_ACTIVE;
                        active_q    <= target;
                        mode_en_q   <= target_oh;
                        switching_q <= 1'b0;
                        loud_q      <= 1'b1;
                        speaker_q   <= 1'b0;
                    end else begin
                        mute_cnt <= mute_cnt + 1'b1;
`ifdef MODE_SWITCH_CHIME_EN
                        if (chime_cnt == CHIME_LAST) begin
                            chime_cnt <= '0;
                            speaker_q <= ~speaker_q;
                        end else begin
                            chime_cnt <= chime_cnt + 1'b1;
                        end
`else
                        speaker_q <= 1'b0;
`endif
                    end
                end
                default: state <= ST_ACTIVE;
            endcase
        end
    end

    assign bus.speaker     = speaker_q;
    assign bus.note_out    = note_q;
    assign bus.active_mode = active_q;
    assign bus.mode_en     = mode_en_q;
    assign bus.switching   = switching_q;
    assign bus.loud        = loud_q;
endmodule

// File: tb/tb_mode_switcher.sv
// tb/tb_mode_switcher.sv - scoreboard bench for mode_switcher against a run-length reference model
module tb_mode_switcher;
    localparam int N    = 4;
    localparam int SW   = 3;
    localparam int NW   = 4;
    localparam int MUTE = 8;
    localparam int STB0 = 16;
    localparam int STB1 = 3;

    typedef struct packed {
        logic       spk;
        logic [3:0] note;
        logic [2:0] act;
        logic [3:0] en;
        logic       sw;
        logic       loud;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [3:0]  spk = 4'b0001;
    logic [15:0] note = 16'h0;
    bit          force_spk = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    exp_t q0[$];
    exp_t q1[$];

    int m_active [2];
    int m_target [2];
    int m_elapsed[2];
    bit m_mute   [2];
    int h_val    [2];
    int h_run    [2];

    always #5 clk = ~clk;

    mode_switcher_if #(.N_MODES(N), .SEL_W(SW), .NOTE_W(NW)) bus0 ();
    mode_switcher_if #(.N_MODES(N), .SEL_W(SW), .NOTE_W(NW)) bus1 ();

    assign bus0.mode_select = sel;
    assign bus0.spk_in      = spk;
    assign bus0.note_in     = note;
    assign bus1.mode_select = sel;
    assign bus1.spk_in      = spk;
    assign bus1.note_in     = note;

    mode_switcher #(.STABLE_CYCLES(STB0), .MUTE_CYCLES(MUTE)) dut (
        .clk(clk), .reset(reset), .bus(bus0));
    mode_switcher #(.STABLE_CYCLES(STB1), .MUTE_CYCLES(MUTE)) dut_fast (
        .clk(clk), .reset(reset), .bus(bus1));

    function automatic int mapped(input int x);
        return (x < N) ? x : 0;
    endfunction

    function automatic int stb_len(input int k);
        return (k == 0) ? STB0 : STB1;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.spk = 1'b0; e.note = 4'h0; e.act = 3'd0; e.en = 4'b0001; e.sw = 1'b0; e.loud = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 0; m_target[k] = 0; m_elapsed[k] = 0; m_mute[k] = 1'b0;
            h_val[k] = 0; h_run[k] = 1;
        end
    endtask

    // h_run = how many consecutive samples (reset counts as one of DEFAULT) have held h_val
    task automatic model_edge(input int k, output exp_t e);
        int ref_m;
        bit req;
        ref_m = m_mute[k] ? m_target[k] : m_active[k];
        req = (h_run[k] >= stb_len(k)) && (mapped(h_val[k]) != ref_m);
        e.spk = 1'b0;
        e.note = 4'h0;
        if (!m_mute[k]) begin
            if (req) begin
                m_mute[k] = 1'b1; m_target[k] = mapped(h_val[k]); m_elapsed[k] = 0;
            end else begin
                e.spk = spk[m_active[k]];
                e.note = 4'((note >> (4 * m_active[k])) & 16'hF);
            end
        end else if (req) begin
            m_target[k] = mapped(h_val[k]); m_elapsed[k] = 0;
        end else if (m_elapsed[k] == MUTE - 1) begin
            m_mute[k] = 1'b0; m_active[k] = m_target[k];
        end else begin
            m_elapsed[k]++;
        end
        if (int'(sel) == h_val[k]) begin
            if (h_run[k] < stb_len(k)) h_run[k]++;
        end else begin
            h_val[k] = int'(sel); h_run[k] = 1;
        end
        e.act = 3'(m_active[k]);
        e.en = m_mute[k] ? 4'b0000 : 4'(1 << m_active[k]);
        e.sw = m_mute[k];
        e.loud = !m_mute[k];
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        q0.push_back(reset_exp());
        q1.push_back(reset_exp());
    endtask

    task automatic cycle(input int s, input bit pulse);
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        sel = 3'(s);
        spk = force_spk ? 4'b0001 : 4'($urandom);
        note = 16'($urandom);
        if (pulse) begin
            reset = 1'b0;
            #2;
            model_reset();
            reset = 1'b1;
        end
        model_edge(0, e); q0.push_back(e);
        model_edge(1, e); q1.push_back(e);
    endtask

    task automatic hold(input int s, input int n);
        for (int i = 0; i < n; i++) cycle(s, 1'b0);
    endtask

    task automatic check(input string name, input int k, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0d want=%0d", name, k, cyc, got, want);
        end
    endtask

    task automatic compare(input int k, input exp_t w, input exp_t g);
        check("speaker", k, int'(g.spk), int'(w.spk));
        check("note_out", k, int'(g.note), int'(w.note));
        check("active_mode", k, int'(g.act), int'(w.act));
        check("mode_en", k, int'(g.en), int'(w.en));
        check("switching", k, int'(g.sw), int'(w.sw));
        check("loud", k, int'(g.loud), int'(w.loud));
    endtask

    initial begin
        exp_t w;
        exp_t g;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q0.size() > 0) begin
                w = q0.pop_front();
                g = {bus0.speaker, bus0.note_out, bus0.active_mode, bus0.mode_en, bus0.switching, bus0.loud};
                compare(0, w, g);
            end
            if (q1.size() > 0) begin
                w = q1.pop_front();
                g = {bus1.speaker, bus1.note_out, bus1.active_mode, bus1.mode_en, bus1.switching, bus1.loud};
                compare(1, w, g);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) hold_reset();
        hold(0, 3);
        force_spk = 1'b0;
        hold(0, 20);
        hold(1, 40);
        for (int t = 0; t < 6; t++) hold(t % 2, 10);
        hold(2, 40);
        hold(7, 40);
        hold(7, 10);
        hold(5, 30);
        hold(6, 30);
        hold(3, 20);
        cycle(3, 1'b1);
        hold(3, 40);
        for (int seg = 0; seg < 50; seg++) begin
            int v;
            int n;
            v = $urandom_range(0, 7);
            n = $urandom_range(1, 25);
            for (int i = 0; i < n; i++) cycle(v, ($urandom_range(0, 199) == 0));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0", q0.size() + q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
